// File: rtl/fifo_drain_pkg.sv
// Shared types and sizes for the FIFO drain controller.
package fifo_drain_pkg;

  localparam int unsigned DW_DEFAULT  = 32;
  localparam int unsigned FLUSH_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PART  = 2'd1,
    FLUSH = 2'd2
  } drain_state_e;

  // One buffered word plus the tag saying it was read during a flush.
  typedef struct packed {
    logic                  flush;
    logic [DW_DEFAULT-1:0] data;
  } drain_entry_t;

endpackage

// File: rtl/drain_skid_buf.sv
// Two-entry buffer between the FIFO read port and the output stream.
module drain_skid_buf
  import fifo_drain_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  drain_entry_t push_entry,
  input  logic         pop,
  output drain_entry_t head,
  output logic         full,
  output logic         empty
);

  drain_entry_t mem_q [2];
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         wr_ptr;

  // Next write slot sits count entries past the head.
  assign wr_ptr = rd_ptr_q ^ count_q[0];

  // Occupancy update; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage, head pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) mem_q[wr_ptr] <= push_entry;
      if (pop)  rd_ptr_q      <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Pulls full words from the flushable FIFO, forwards them on a valid/ready
// stream and forces a flush when partial data lingers or software asks.
module fifo_drain_ctrl
  import fifo_drain_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned DW      = DW_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_data_avail_i,
  input  logic                   fifo_empty_i,
  input  logic [DW-1:0]          fifo_rd_data_i,
  input  logic                   fifo_flush_done_i,
  output logic                   fifo_rd_valid_o,
  output logic                   fifo_flush_o,
  input  logic                   sw_flush_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [DW-1:0]          m_data_o,
  output logic                   m_flush_o,
  output logic [FLUSH_CNT_W-1:0] flush_count_o
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT);

  drain_state_e           state_q, state_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  drain_entry_t push_entry;
  drain_entry_t head;
  logic         buf_full;
  logic         buf_empty;
  logic         pop;

  // Read only when a word is ready and the buffer has room.
  assign fifo_rd_valid_o = fifo_data_avail_i && !buf_full;
  assign push_entry      = '{flush: fifo_flush_o, data: DW_DEFAULT'(fifo_rd_data_i)};
  assign pop             = m_valid_o && m_ready_i;

  drain_skid_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_rd_valid_o),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (buf_full),
    .empty      (buf_empty)
  );

  assign m_valid_o     = !buf_empty;
  assign m_data_o      = DW'(head.data);
  assign m_flush_o     = head.flush;
  assign fifo_flush_o  = (state_q == FLUSH);
  assign flush_count_o = flush_cnt_q;

  // Flush decision: the IDLE cycle that first sees partial data counts as
  // pending cycle one, so PART fires one timer step early.
  always_comb begin
    state_d     = state_q;
    timer_d     = '0;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty_i && !fifo_data_avail_i) state_d = PART;
        else if (sw_flush_i && !fifo_empty_i)    state_d = FLUSH;
      end
      PART: begin
        if (fifo_empty_i || fifo_data_avail_i) begin
          state_d = IDLE;
        end else if (sw_flush_i || timer_q == TMR_W'(TIMEOUT - 2)) begin
          state_d = FLUSH;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      FLUSH: begin
        if (fifo_flush_done_i) begin
          state_d = IDLE;
          if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + FLUSH_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, timer and flush counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of the drain behaviour.
module tb_fifo_drain_ctrl;
  import fifo_drain_pkg::*;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fifo_data_avail_i = 1'b0;
  logic        fifo_empty_i = 1'b1;
  logic [31:0] fifo_rd_data_i = '0;
  logic        fifo_flush_done_i = 1'b0;
  logic        fifo_rd_valid_o;
  logic        fifo_flush_o;
  logic        sw_flush_i = 1'b0;
  logic        m_valid_o;
  logic        m_ready_i = 1'b0;
  logic [31:0] m_data_o;
  logic        m_flush_o;
  logic [15:0] flush_count_o;

  always #5 clk = ~clk;

  fifo_drain_ctrl #(.TIMEOUT(TIMEOUT), .DW(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .fifo_data_avail_i (fifo_data_avail_i),
    .fifo_empty_i      (fifo_empty_i),
    .fifo_rd_data_i    (fifo_rd_data_i),
    .fifo_flush_done_i (fifo_flush_done_i),
    .fifo_rd_valid_o   (fifo_rd_valid_o),
    .fifo_flush_o      (fifo_flush_o),
    .sw_flush_i        (sw_flush_i),
    .m_valid_o         (m_valid_o),
    .m_ready_i         (m_ready_i),
    .m_data_o          (m_data_o),
    .m_flush_o         (m_flush_o),
    .flush_count_o     (flush_count_o)
  );

  int vectors = 0;
  int errors  = 0;

  // Model: buffered words, whether a flush is outstanding, how many
  // consecutive cycles partial data has been pending, completed flushes.
  logic [32:0] mq[$];
  bit          m_flushing;
  int          m_pend;
  int          m_fcount;

  // Outputs sampled in the most recent step.
  logic        s_rd, s_flush, s_mvalid, s_mflush;
  logic [31:0] s_mdata;
  logic [15:0] s_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_flushing = 1'b0;
    m_pend     = 0;
    m_fcount   = 0;
  endtask

  // One clock: drive at negedge, compare before posedge, advance model.
  task automatic step(input bit avail, input bit empty, input logic [31:0] data,
                      input bit done, input bit sw, input bit ready);
    bit prd;
    bit partial;
    @(negedge clk);
    fifo_data_avail_i = avail;
    fifo_empty_i      = empty;
    fifo_rd_data_i    = data;
    fifo_flush_done_i = done;
    sw_flush_i        = sw;
    m_ready_i         = ready;
    #1;
    s_rd = fifo_rd_valid_o; s_flush = fifo_flush_o; s_mvalid = m_valid_o;
    s_mdata = m_data_o; s_mflush = m_flush_o; s_cnt = flush_count_o;
    prd = avail && (mq.size() < 2);
    chk("rd_valid", 64'(s_rd), 64'(prd));
    chk("flush", 64'(s_flush), 64'(m_flushing));
    chk("m_valid", 64'(s_mvalid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("m_data", 64'(s_mdata), 64'(mq[0][31:0]));
      chk("m_flush", 64'(s_mflush), 64'(mq[0][32]));
    end
    chk("flush_count", 64'(s_cnt), 64'(m_fcount));
    @(posedge clk);
    if (mq.size() != 0 && ready) void'(mq.pop_front());
    if (prd) mq.push_back({m_flushing, data});
    partial = !empty && !avail;
    if (m_flushing) begin
      if (done) begin
        m_flushing = 1'b0;
        if (m_fcount < 65535) m_fcount++;
      end
    end else if (m_pend == 0) begin
      if (partial) m_pend = 1;
      else if (sw && !empty) m_flushing = 1'b1;
    end else if (!partial) begin
      m_pend = 0;
    end else begin
      m_pend++;
      if (sw || m_pend >= int'(TIMEOUT)) begin
        m_flushing = 1'b1;
        m_pend     = 0;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_flush"}, 64'(fifo_flush_o), 64'(0));
    chk({tag, "_m_valid"}, 64'(m_valid_o), 64'(0));
    chk({tag, "_m_data"}, 64'(m_data_o), 64'(0));
    chk({tag, "_m_flush"}, 64'(m_flush_o), 64'(0));
    chk({tag, "_count"}, 64'(flush_count_o), 64'(0));
  endtask

  initial begin
    logic [31:0] src[$];
    logic [31:0] outs[$];
    int          rdcnt;

    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Streaming four words with ready high
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 32'(32'h11111111 * (i + 1)), 1'b0, 1'b0, 1'b1);
      chk("stream_rd", 64'(s_rd), 64'(1));
      if (i > 0) begin
        chk("stream_data", 64'(s_mdata), 64'(32'(32'h11111111 * i)));
        chk("stream_tag", 64'(s_mflush), 64'(0));
      end
    end
    step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1);
    chk("stream_last", 64'(s_mdata), 64'(32'h44444444));
    step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1);
    chk("stream_idle_valid", 64'(s_mvalid), 64'(0));
    chk("stream_no_flush", 64'(s_flush), 64'(0));

    // Timeout flush: flush visible exactly TIMEOUT cycles after first partial
    for (int c = 0; c <= 16; c++) begin
      step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("timeout_edge", 64'(s_flush), 64'(c == 16));
    end
    step(1'b1, 1'b0, 32'h00000ABC, 1'b0, 1'b0, 1'b1);
    chk("pad_read", 64'(s_rd), 64'(1));
    step(1'b0, 1'b1, '0, 1'b1, 1'b0, 1'b1);
    chk("pad_data", 64'(s_mdata), 64'(32'h00000ABC));
    chk("pad_tag", 64'(s_mflush), 64'(1));
    step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1);
    chk("pad_done_flush", 64'(s_flush), 64'(0));
    chk("pad_done_count", 64'(s_cnt), 64'(1));

    // Partial completes before timeout, then a fresh full-length timeout
    for (int c = 0; c < 10; c++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'hCAFE0001, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1);
    chk("early_no_flush", 64'(s_flush), 64'(0));
    chk("early_tag", 64'(s_mflush), 64'(0));
    for (int c = 0; c <= 16; c++) begin
      step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("retimeout_edge", 64'(s_flush), 64'(c == 16));
    end
    step(1'b0, 1'b1, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1);
    chk("retimeout_count", 64'(s_cnt), 64'(2));

    // Backpressure: only two reads, then an in-order drain
    for (int i = 0; i < 4; i++) src.push_back(32'hB0000000 + 32'(i));
    rdcnt = 0;
    for (int c = 0; c < 6; c++) begin
      step(src.size() > 0, src.size() == 0, (src.size() > 0) ? src[0] : 32'h0, 1'b0, 1'b0, 1'b0);
      if (s_rd) begin
        rdcnt++;
        void'(src.pop_front());
      end
    end
    chk("bp_reads", 64'(rdcnt), 64'(2));
    chk("bp_rd_low", 64'(s_rd), 64'(0));
    chk("bp_hold", 64'(s_mdata), 64'(32'hB0000000));
    for (int c = 0; c < 10; c++) begin
      step(src.size() > 0, src.size() == 0, (src.size() > 0) ? src[0] : 32'h0, 1'b0, 1'b0, 1'b1);
      if (s_mvalid) outs.push_back(s_mdata);
      if (s_rd) void'(src.pop_front());
    end
    chk("bp_out_count", 64'(outs.size()), 64'(4));
    for (int i = 0; i < 4 && i < outs.size(); i++)
      chk("bp_order", 64'(outs[i]), 64'(32'hB0000000 + 32'(i)));

    // Software flush: ignored when empty, honoured from PART, extra pulses ignored
    step(1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1);
    chk("sw_empty_ignored", 64'(s_flush), 64'(0));
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("sw_part_before", 64'(s_flush), 64'(0));
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("sw_part_next", 64'(s_flush), 64'(1));
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1);
    chk("sw_count", 64'(s_cnt), 64'(3));
    chk("sw_done_flush", 64'(s_flush), 64'(0));

    // Reset in the middle of a flush with one word buffered
    step(1'b1, 1'b0, 32'hD00D0001, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("midflush_flush", 64'(s_flush), 64'(1));
    chk("midflush_valid", 64'(s_mvalid), 64'(1));
    @(negedge clk);
    fifo_data_avail_i = 1'b0;
    fifo_empty_i      = 1'b1;
    sw_flush_i        = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'hE0000000 + 32'(i), 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1);
    chk("resume_data", 64'(s_mdata), 64'(32'hE0000002));

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bit e, a;
      e = ($urandom % 4) == 0;
      a = !e && (($urandom % 2) == 1);
      step(a, e, $urandom, ($urandom % 6) == 0, ($urandom % 12) == 0, ($urandom % 4) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
